redstone_repeater: RTL and testbench

- Non-inverting, delay-programmable redstone element; the forward-signal counterpart of the inverting torch in the soup/redstone library.
- Delays each input level change by 1-4 ticks, one tick per clk edge.
- Extends input pulses shorter than the delay to exactly the delay length.
- Can be locked from a side input so that its output holds.
- Chains with torches and other repeaters to build signal lines and clocks.

---
 rtl/redstone_pkg.sv | 15 +
 rtl/redstone_repeater.sv | 96 +++++++++
 tb/tb_redstone_repeater.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/redstone_pkg.sv
// Shared types and defaults for the redstone repeater.
// Holds the repeater state encoding and delay sizing constants.
package redstone_pkg;

    typedef enum logic [1:0] {
        LOW,
        RISE,
        HIGH,
        FALL
    } rep_state_e;

    localparam int REDSTONE_MAX_DELAY = 4;
    localparam int REDSTONE_DELAY_W   = 2;

endpackage

// File: rtl/redstone_repeater.sv
// Non-inverting repeater with a programmable 1..MAX_DELAY tick delay.
// Optional side lock freezes all state when REDSTONE_LOCK_EN is defined.
module redstone_repeater
    import redstone_pkg::*;
#(
    parameter int MAX_DELAY = REDSTONE_MAX_DELAY,
    parameter int DELAY_W   = REDSTONE_DELAY_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in,
    input  logic [DELAY_W-1:0] delay_sel,
`ifdef REDSTONE_LOCK_EN
    input  logic               lock,
`endif
    output logic               out,
    output logic               busy
);

    rep_state_e         state_q;
    logic [DELAY_W-1:0] cnt_q;
    logic               out_q;
    logic [DELAY_W-1:0] sel_d;
    logic               hold;

`ifdef REDSTONE_LOCK_EN
    assign hold = lock;
`else
    assign hold = 1'b0;
`endif

    // Clamp the programmed delay so it never exceeds MAX_DELAY ticks.
    always_comb begin
        sel_d = delay_sel;
        if (delay_sel > DELAY_W'(MAX_DELAY - 1)) begin
            sel_d = DELAY_W'(MAX_DELAY - 1);
        end
    end

    // Level FSM: resample in only when settled, count down a committed change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOW;
            cnt_q   <= '0;
            out_q   <= 1'b0;
        end else if (!hold) begin
            unique case (state_q)
                LOW: begin
                    if (in) begin
                        if (sel_d == '0) begin
                            out_q   <= 1'b1;
                            state_q <= HIGH;
                        end else begin
                            cnt_q   <= sel_d;
                            state_q <= RISE;
                        end
                    end
                end
                RISE: begin
                    if (cnt_q == DELAY_W'(1)) begin
                        out_q   <= 1'b1;
                        state_q <= HIGH;
                    end else begin
                        cnt_q <= cnt_q - DELAY_W'(1);
                    end
                end
                HIGH: begin
                    if (!in) begin
                        if (sel_d == '0) begin
                            out_q   <= 1'b0;
                            state_q <= LOW;
                        end else begin
                            cnt_q   <= sel_d;
                            state_q <= FALL;
                        end
                    end
                end
                FALL: begin
                    if (cnt_q == DELAY_W'(1)) begin
                        out_q   <= 1'b0;
                        state_q <= LOW;
                    end else begin
                        cnt_q <= cnt_q - DELAY_W'(1);
                    end
                end
                default: begin
                    state_q <= LOW;
                end
            endcase
        end
    end

    assign out  = out_q;
    assign busy = (state_q == RISE) || (state_q == FALL);

endmodule

// File: tb/tb_redstone_repeater.sv
// Scoreboard bench for redstone_repeater.
// Expected out/busy per edge are queued at drive time, popped after the edge.
module tb_redstone_repeater;
    import redstone_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in;
    logic       lock;
    logic [1:0] delay_sel;
    logic       out;
    logic       busy;

    typedef struct {
        logic o;
        logic b;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   hi_cnt = 0;

    bit   m_out;
    bit   m_pend;
    int   m_left;

    always #5 clk = ~clk;

    redstone_repeater dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .delay_sel (delay_sel),
`ifdef REDSTONE_LOCK_EN
        .lock      (lock),
`endif
        .out       (out),
        .busy      (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] act,
                             input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
        end
    endtask

    // Drive one cycle of stimulus and queue the expected post-edge outputs.
    task automatic step(input logic i, input logic [1:0] s, input logic l,
                        input logic r);
        bit eff_lock;
        @(negedge clk);
        if (out === 1'b1) hi_cnt++;
        in = i;
        delay_sel = s;
        lock = l;
        rst = r;
`ifdef REDSTONE_LOCK_EN
        eff_lock = l;
`else
        eff_lock = 1'b0;
`endif
        if (r) begin
            m_out = 0;
            m_pend = 0;
            m_left = 0;
        end else if (eff_lock) begin
        end else if (m_pend) begin
            m_left--;
            if (m_left == 0) begin
                m_out = ~m_out;
                m_pend = 0;
            end
        end else if (i != m_out) begin
            if (s == 2'd0) begin
                m_out = i;
            end else begin
                m_pend = 1;
                m_left = int'(s);
            end
        end
        sbq.push_back('{o: m_out, b: m_pend});
    endtask

    // Compare DUT outputs against the queued expectation after each edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check_val("out", {31'd0, out}, {31'd0, e.o});
            check_val("busy", {31'd0, busy}, {31'd0, e.b});
        end
    end

    initial begin
        rst = 1'b1;
        in = 1'b0;
        lock = 1'b0;
        delay_sel = 2'd0;
        m_out = 0;
        m_pend = 0;
        m_left = 0;
        #1;
        check_val("reset_out", {31'd0, out}, 32'd0);
        check_val("reset_busy", {31'd0, busy}, 32'd0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // Reset mid-RISE with D=3.
        step(1, 2, 0, 0);
        step(0, 2, 0, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("midrise_rst_out", {31'd0, out}, 32'd0);
        check_val("midrise_rst_busy", {31'd0, busy}, 32'd0);
        m_out = 0;
        m_pend = 0;
        m_left = 0;
        step(0, 2, 0, 1);
        repeat (3) step(0, 2, 0, 0);

        // Latency sweep over every delay setting.
        for (int s = 0; s < 4; s++) begin
            repeat (s + 3) step(1, 2'(s), 0, 0);
            repeat (s + 3) step(0, 2'(s), 0, 0);
        end

        // One-cycle pulse with D=4 stretches to four cycles.
        hi_cnt = 0;
        step(1, 3, 0, 0);
        repeat (7) step(0, 3, 0, 0);
        check_val("pulse_d4_width", hi_cnt, 32'd4);

        // Three-cycle pulse with D=2 stays three cycles.
        hi_cnt = 0;
        repeat (3) step(1, 1, 0, 0);
        repeat (4) step(0, 1, 0, 0);
        check_val("pulse_d2_width", hi_cnt, 32'd3);

        // Glitch during RISE with D=3 still produces a three-cycle pulse.
        hi_cnt = 0;
        step(1, 2, 0, 0);
        repeat (6) step(0, 2, 0, 0);
        check_val("glitch_d3_width", hi_cnt, 32'd3);

        // Delay change mid-count: rise lands on the old schedule, fall uses D=1.
        step(1, 3, 0, 0);
        repeat (4) step(1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0);

`ifdef REDSTONE_LOCK_EN
        // Freeze for five cycles one cycle into RISE with D=4.
        step(1, 3, 0, 0);
        repeat (5) step(1, 3, 1, 0);
        repeat (4) step(1, 3, 0, 0);
        repeat (2) step(0, 0, 0, 0);
        // Lock in LOW holds out low despite in=1.
        repeat (3) step(1, 0, 1, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
`endif

        repeat (2) @(posedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
